// File: rtl/xnor_cmp_pkg.sv
// rtl/xnor_cmp_pkg.sv - shared types and helpers for the bit-serial XNOR comparator
package xnor_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a match count of 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xnor_serial_compare_if.sv
// rtl/xnor_serial_compare_if.sv - start/busy/done handshake and operand/result bundle
interface xnor_serial_compare_if
    import xnor_cmp_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = count_width(WIDTH);

    logic          start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic          busy;
    logic          done;
    logic          equal;
    logic [CW-1:0] match_count;

    modport master (
        output start, op_a, op_b,
        input  busy, done, equal, match_count
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, equal, match_count
    );

endinterface

// File: rtl/xnor_gate.sv
// rtl/xnor_gate.sv - single-bit XNOR primitive
module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

// File: rtl/xnor_serial_compare.sv
// rtl/xnor_serial_compare.sv - bit-serial equality/popcount comparator on one shared XNOR
// Optional build macro XNOR_CMP_EARLY_EXIT_EN: stop at the first mismatching bit.
module xnor_serial_compare
    import xnor_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xnor_serial_compare_if.slave  bus
);
    localparam int CW = count_width(WIDTH);
    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    run_cnt;
    logic             run_eq;
    logic             equal_q;
    logic [CW-1:0]    count_q;
    logic             bit_match;
    logic             last_bit;

    xnor_gate u_xnor (
        .a (sh_a[0]),
        .b (sh_b[0]),
        .y (bit_match)
    );

    assign last_bit = (idx == IW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
`ifdef XNOR_CMP_EARLY_EXIT_EN
                if (last_bit || !bit_match) state_next = DONE;
`else
                if (last_bit) state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are committed on the same edge that enters DONE, so they
    // include the bit being processed on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a    <= '0;
            sh_b    <= '0;
            idx     <= '0;
            run_cnt <= '0;
            run_eq  <= 1'b0;
            equal_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                sh_a    <= bus.op_a;
                sh_b    <= bus.op_b;
                idx     <= '0;
                run_cnt <= '0;
                run_eq  <= 1'b1;
            end else if (state == RUN) begin
                sh_a    <= sh_a >> 1;
                sh_b    <= sh_b >> 1;
                idx     <= idx + 1'b1;
                run_cnt <= run_cnt + CW'(bit_match);
                run_eq  <= run_eq & bit_match;
                if (state_next == DONE) begin
                    equal_q <= run_eq & bit_match;
                    count_q <= run_cnt + CW'(bit_match);
                end
            end
        end
    end

    always_comb begin
        bus.busy        = (state == RUN);
        bus.done        = (state == DONE);
        bus.equal       = equal_q;
        bus.match_count = count_q;
    end

endmodule

// File: tb/tb_xnor_serial_compare.sv
// tb/tb_xnor_serial_compare.sv - directed self-checking bench for xnor_serial_compare
module tb_xnor_serial_compare;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    xnor_serial_compare_if #(.WIDTH(8)) bus ();

    xnor_serial_compare #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one compare; lat = cycles from accepting edge to done (-1 on timeout).
    task automatic run_compare(input logic [7:0] a, input logic [7:0] b,
                               output int lat, output logic eq_mid,
                               output logic [3:0] cnt_mid, output int overlap);
        lat     = -1;
        overlap = 0;
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        eq_mid    = bus.equal;
        cnt_mid   = bus.match_count;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.equal !== 1'b0 || bus.match_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b equal=%b count=%0d, required all 0",
                     bus.busy, bus.done, bus.equal, bus.match_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_equal_words();
        int lat; logic em; logic [3:0] cm; int ov;
        run_compare(8'hA5, 8'hA5, lat, em, cm, ov);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL eq_latency: got %0d required 8", lat); end
        checks++;
        if (bus.equal !== 1'b1 || bus.match_count !== 4'd8) begin
            failures++;
            $display("FAIL eq_result: equal=%b count=%0d required equal=1 count=8", bus.equal, bus.match_count);
        end
        checks++;
        if (ov !== 0) begin failures++; $display("FAIL eq_overlap: busy&done cycles=%0d required 0", ov); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.equal !== 1'b1 || bus.match_count !== 4'd8) begin
            failures++;
            $display("FAIL eq_hold: equal=%b count=%0d required equal=1 count=8", bus.equal, bus.match_count);
        end
    endtask

    task automatic test_all_mismatch();
        int lat; logic em; logic [3:0] cm; int ov;
        run_compare(8'hFF, 8'h00, lat, em, cm, ov);
        checks++;
        if (em !== 1'b1 || cm !== 4'd8) begin
            failures++;
            $display("FAIL hold_during_run: equal=%b count=%0d required equal=1 count=8", em, cm);
        end
`ifdef XNOR_CMP_EARLY_EXIT_EN
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL ff00_latency: got %0d required 1", lat); end
`else
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL ff00_latency: got %0d required 8", lat); end
`endif
        checks++;
        if (bus.equal !== 1'b0 || bus.match_count !== 4'd0) begin
            failures++;
            $display("FAIL ff00_result: equal=%b count=%0d required equal=0 count=0", bus.equal, bus.match_count);
        end
    endtask

    task automatic test_lsb_mismatch();
        int lat; logic em; logic [3:0] cm; int ov;
        logic [3:0] exp_cnt; int exp_lat;
`ifdef XNOR_CMP_EARLY_EXIT_EN
        exp_cnt = 4'd0; exp_lat = 1;
`else
        exp_cnt = 4'd7; exp_lat = 8;
`endif
        run_compare(8'hF0, 8'hF1, lat, em, cm, ov);
        checks++;
        if (lat !== exp_lat) begin failures++; $display("FAIL f0f1_latency: got %0d required %0d", lat, exp_lat); end
        checks++;
        if (bus.equal !== 1'b0 || bus.match_count !== exp_cnt) begin
            failures++;
            $display("FAIL f0f1_result: equal=%b count=%0d required equal=0 count=%0d",
                     bus.equal, bus.match_count, exp_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        int ov;
        dones = 0;
        ov    = 0;
        @(negedge clk);
        bus.op_a  = 8'h3C;
        bus.op_b  = 8'h3C;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.op_b  = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) dones++;
            if (bus.busy && bus.done) ov++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL ignore_start_dones: got %0d required 1", dones); end
        checks++;
        if (bus.equal !== 1'b1 || bus.match_count !== 4'd8) begin
            failures++;
            $display("FAIL ignore_start_result: equal=%b count=%0d required equal=1 count=8",
                     bus.equal, bus.match_count);
        end
        checks++;
        if (ov !== 0) begin failures++; $display("FAIL ignore_start_overlap: got %0d required 0", ov); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic em; logic [3:0] cm; int ov;
        int dones;
        logic [3:0] exp_cnt; int exp_lat;
        dones = 0;
        @(negedge clk);
        bus.op_a  = 8'h55;
        bus.op_b  = 8'h55;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.equal !== 1'b0 || bus.match_count !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b equal=%b count=%0d required all 0",
                     bus.busy, bus.done, bus.equal, bus.match_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL reset_discard: dones=%0d required 0", dones); end
`ifdef XNOR_CMP_EARLY_EXIT_EN
        exp_cnt = 4'd0; exp_lat = 1;
`else
        exp_cnt = 4'd7; exp_lat = 8;
`endif
        run_compare(8'h0F, 8'h0E, lat, em, cm, ov);
        checks++;
        if (lat !== exp_lat || bus.match_count !== exp_cnt || bus.equal !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: lat=%0d count=%0d equal=%b required lat=%0d count=%0d equal=0",
                     lat, bus.match_count, bus.equal, exp_lat, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int ov;
        int bad_gap;
        int accept_in_done;
        ov = 0;
        bad_gap = 0;
        accept_in_done = 0;
        @(negedge clk);
        bus.op_a  = 8'h00;
        bus.op_b  = 8'h00;
        bus.start = 1'b1;
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            if (bus.busy && bus.done) ov++;
            if (bus.done) begin
                done_at.push_back(k);
                @(negedge clk);
                k++;
                if (bus.busy) accept_in_done++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (done_at.size() < 4) begin
            failures++;
            $display("FAIL b2b_count: dones=%0d required >=4", done_at.size());
        end
        for (int i = 1; i < done_at.size(); i++)
            if (done_at[i] - done_at[i-1] != 10) bad_gap++;
        checks++;
        if (bad_gap !== 0) begin failures++; $display("FAIL b2b_spacing: bad gaps=%0d required 0 (period 10)", bad_gap); end
        checks++;
        if (ov !== 0 || accept_in_done !== 0) begin
            failures++;
            $display("FAIL b2b_overlap: overlap=%0d busy_after_done=%0d required 0/0", ov, accept_in_done);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_equal_words();
        test_all_mismatch();
        test_lsb_mismatch();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
